fnd_scan_dec: RTL and testbench
===============================

// Module: fnd_scan_dec
// PURPOSE
//  Parametrised time-multiplexed 7-segment driver for the clock display. Takes NUM_DIGIT
//  packed BCD/hex digits plus per-digit enable, blink and dot masks, and scans them one
//  digit at a time onto a shared segment bus with one common line per digit. Blink timing
//  is generated internally. Sits between the clock/setting logic and the FND pins.
// PARAMETERS
//  NUM_DIGIT   6       number of digits scanned (>=2)
//  SCAN_DIV    1000    clk cycles each digit stays lit (>=2)
//  BLINK_DIV   5000000 clk cycles per blink half-period (>=2)
//  HEX_EN      0       1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 show blank
//  SEG_ACT_LOW 0       1: o_seg driven active-low (segment on = 0)
//  COM_ACT_LOW 1       1: o_com driven active-low (selected digit = 0)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous reset, active-high
//  i_digits     in   4*NUM_DIGIT  digit codes; digit k = i_digits[4k+3:4k], k=0 rightmost
//  i_dis_mask   in   NUM_DIGIT    1 = digit enabled; 0 = digit blank (dot also off)
//  i_blink_mask in   NUM_DIGIT    1 = digit blinks when i_blink_en=1
//  i_dot        in   NUM_DIGIT    1 = decimal point of digit k on
//  i_blink_en   in   1            global blink enable
//  o_seg        out  8            {dp,a,b,c,d,e,f,g} for currently selected digit
//  o_com        out  NUM_DIGIT    one-hot digit select (polarity per COM_ACT_LOW)
//  o_digit_idx  out  clog2(N)     index of digit currently driven
//  o_blink_ph   out  1            blink phase: 1 = blinking digits visible
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: scan_cnt=0, blink_cnt=0, o_blink_ph=1, o_digit_idx=0, o_com all inactive,
//   o_seg all segments off (polarity applied), snapshot regs cleared to 0.
//  Scan counter: scan_cnt counts 0..SCAN_DIV-1; scan_tick=1 when scan_cnt==SCAN_DIV-1,
//   then wraps to 0. On scan_tick idx advances; NUM_DIGIT-1 wraps to 0.
//  Snapshot: i_digits, i_dis_mask, i_blink_mask, i_dot captured into snapshot regs on the
//   scan_tick that wraps idx to 0 (and first tick after reset) -> one full frame coherent,
//   no tearing when inputs change mid-frame. i_blink_en is used live.
//  Blink counter: blink_cnt 0..BLINK_DIV-1; o_blink_ph toggles when blink_cnt==BLINK_DIV-1.
//   i_blink_en=0 forces visibility regardless of phase; counter keeps running.
//  Digit visible = dis_mask[k] & ~(i_blink_en & blink_mask[k] & ~o_blink_ph).
//  Decode (a..g, before polarity): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//   5=1011011 6=1011111 7=1110000 8=1111111 9=1110011; HEX_EN=1: A=1110111 b=0011111
//   C=1001110 d=0111101 E=1001111 F=1000111; else 10-15 -> 0000000.
//   dp = dot[k] & visible. Invisible digit -> all 8 bits off.
//  Latency: o_seg/o_com/o_digit_idx registered; change exactly 1 clk after scan_tick.
//   No blanking gap between digits; exactly one o_com bit active at any time after the
//   first scan_tick following reset.
//  Polarity: SEG_ACT_LOW / COM_ACT_LOW invert the respective output bus only.
//  Reset mid-frame: all state returns to reset values next edge; scan restarts at digit 0.
//  Simultaneous scan_tick and blink toggle: new digit uses the new blink phase.
// TESTING
//  1 Reset: rst=1 3 clks -> o_com=all inactive, o_seg=off, o_blink_ph=1, o_digit_idx=0.
//  2 N=6,SCAN_DIV=4, i_digits=0x123456, masks all 1 -> idx cycles 0..5 every 4 clks,
//    o_seg a..g at idx0=1011111(6), idx5=0110000(1); o_com one-hot each step.
//  3 Change i_digits to 0x999999 mid-frame at idx2 -> idx3..5 still old values; idx0 of
//    next frame shows 9 (1110011).
//  4 BLINK_DIV=8, blink_mask=000011, blink_en=1 -> digits 0,1 off while o_blink_ph=0, on
//    while 1; blink_en=0 -> always on; other digits unaffected.
//  5 HEX_EN=0 vs 1 with digit code 4'hE, i_dot[0]=1 -> blank / 1001111, dp=1 visible;
//    dis_mask[0]=0 -> o_seg fully off including dp.
//  6 SEG_ACT_LOW=1,COM_ACT_LOW=1: digit 8 -> o_seg=8'h00 with dp on; assert rst at idx4 ->
//    next clk idx=0, outputs at reset values.

Source files
------------

// File: rtl/fnd_scan_dec_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fnd_scan_dec_if : digit data/mask inputs and FND pin outputs of fnd_scan_dec
// Revision 1.0
// ---------------------------------------------------------------------------
interface fnd_scan_dec_if #(
    parameter int NUM_DIGIT = 6
);
    localparam int IDX_W = $clog2(NUM_DIGIT);

    logic [4*NUM_DIGIT-1:0] i_digits;
    logic [NUM_DIGIT-1:0]   i_dis_mask;
    logic [NUM_DIGIT-1:0]   i_blink_mask;
    logic [NUM_DIGIT-1:0]   i_dot;
    logic                   i_blink_en;
    logic [7:0]             o_seg;
    logic [NUM_DIGIT-1:0]   o_com;
    logic [IDX_W-1:0]       o_digit_idx;
    logic                   o_blink_ph;

    modport master (
        output i_digits, i_dis_mask, i_blink_mask, i_dot, i_blink_en,
        input  o_seg, o_com, o_digit_idx, o_blink_ph
    );

    modport slave (
        input  i_digits, i_dis_mask, i_blink_mask, i_dot, i_blink_en,
        output o_seg, o_com, o_digit_idx, o_blink_ph
    );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fnd_scan_dec : time-multiplexed 7-segment scanner with frame snapshot/blink
// Revision 1.0
// ---------------------------------------------------------------------------
module fnd_scan_dec #(
    parameter int NUM_DIGIT   = 6,
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_DIV   = 5000000,
    parameter bit HEX_EN      = 1'b0,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit COM_ACT_LOW = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fnd_scan_dec_if.slave    bus
);
    localparam int IDX_W   = $clog2(NUM_DIGIT);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [7:0]           C_SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGIT-1:0] C_COM_OFF = COM_ACT_LOW ? '1 : '0;

    logic [SCAN_W-1:0]      r_scan_cnt;
    logic [BLINK_W-1:0]     r_blink_cnt;
    logic                   r_blink_ph;
    logic                   r_run;
    logic [IDX_W-1:0]       r_idx;
    logic [7:0]             r_seg;
    logic [NUM_DIGIT-1:0]   r_com;
    logic [4*NUM_DIGIT-1:0] r_snap_digits;
    logic [NUM_DIGIT-1:0]   r_snap_dis;
    logic [NUM_DIGIT-1:0]   r_snap_blink;
    logic [NUM_DIGIT-1:0]   r_snap_dot;

    logic                   w_scan_tick;
    logic                   w_blink_tgl;
    logic                   w_ph_next;
    logic [IDX_W-1:0]       w_idx_next;
    logic                   w_capture;
    logic [4*NUM_DIGIT-1:0] w_digits;
    logic [NUM_DIGIT-1:0]   w_dis;
    logic [NUM_DIGIT-1:0]   w_blink;
    logic [NUM_DIGIT-1:0]   w_dot;
    logic [3:0]             w_code;
    logic                   w_visible;
    logic [6:0]             w_seg7;
    logic [7:0]             w_seg_raw;
    logic [NUM_DIGIT-1:0]   w_onehot;

    assign w_scan_tick = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_blink_tgl = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign w_ph_next   = r_blink_ph ^ w_blink_tgl;

    // The first tick after reset lights digit 0 rather than advancing past it.
    assign w_idx_next = (!r_run || (r_idx == IDX_W'(NUM_DIGIT - 1))) ? '0 : r_idx + IDX_W'(1);
    assign w_capture  = w_scan_tick && (w_idx_next == '0);

    // Digit 0 of a new frame must already see the freshly captured inputs.
    assign w_digits = w_capture ? bus.i_digits     : r_snap_digits;
    assign w_dis    = w_capture ? bus.i_dis_mask   : r_snap_dis;
    assign w_blink  = w_capture ? bus.i_blink_mask : r_snap_blink;
    assign w_dot    = w_capture ? bus.i_dot        : r_snap_dot;

    assign w_code    = w_digits[{w_idx_next, 2'b00} +: 4];
    assign w_visible = w_dis[w_idx_next] &
                       ~(bus.i_blink_en & w_blink[w_idx_next] & ~w_ph_next);

    always_comb begin
        w_seg7 = 7'b0000000;
        case (w_code)
            4'h0: w_seg7 = 7'b1111110;
            4'h1: w_seg7 = 7'b0110000;
            4'h2: w_seg7 = 7'b1101101;
            4'h3: w_seg7 = 7'b1111001;
            4'h4: w_seg7 = 7'b0110011;
            4'h5: w_seg7 = 7'b1011011;
            4'h6: w_seg7 = 7'b1011111;
            4'h7: w_seg7 = 7'b1110000;
            4'h8: w_seg7 = 7'b1111111;
            4'h9: w_seg7 = 7'b1110011;
            4'hA: w_seg7 = HEX_EN ? 7'b1110111 : 7'b0000000;
            4'hB: w_seg7 = HEX_EN ? 7'b0011111 : 7'b0000000;
            4'hC: w_seg7 = HEX_EN ? 7'b1001110 : 7'b0000000;
            4'hD: w_seg7 = HEX_EN ? 7'b0111101 : 7'b0000000;
            4'hE: w_seg7 = HEX_EN ? 7'b1001111 : 7'b0000000;
            default: w_seg7 = HEX_EN ? 7'b1000111 : 7'b0000000;
        endcase
    end

    assign w_seg_raw = w_visible ? {w_dot[w_idx_next], w_seg7} : 8'h00;
    assign w_onehot  = NUM_DIGIT'(1) << w_idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt    <= '0;
            r_blink_cnt   <= '0;
            r_blink_ph    <= 1'b1;
            r_run         <= 1'b0;
            r_idx         <= '0;
            r_seg         <= C_SEG_OFF;
            r_com         <= C_COM_OFF;
            r_snap_digits <= '0;
            r_snap_dis    <= '0;
            r_snap_blink  <= '0;
            r_snap_dot    <= '0;
        end else begin
            r_scan_cnt  <= w_scan_tick ? '0 : r_scan_cnt + SCAN_W'(1);
            r_blink_cnt <= w_blink_tgl ? '0 : r_blink_cnt + BLINK_W'(1);
            r_blink_ph  <= w_ph_next;
            if (w_scan_tick) begin
                r_run <= 1'b1;
                r_idx <= w_idx_next;
                r_seg <= SEG_ACT_LOW ? ~w_seg_raw : w_seg_raw;
                r_com <= COM_ACT_LOW ? ~w_onehot : w_onehot;
            end
            if (w_capture) begin
                r_snap_digits <= bus.i_digits;
                r_snap_dis    <= bus.i_dis_mask;
                r_snap_blink  <= bus.i_blink_mask;
                r_snap_dot    <= bus.i_dot;
            end
        end
    end

    assign bus.o_seg       = r_seg;
    assign bus.o_com       = r_com;
    assign bus.o_digit_idx = r_idx;
    assign bus.o_blink_ph  = r_blink_ph;
endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fnd_scan_dec : scoreboard bench; two DUTs cover both decode/polarity sets
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fnd_scan_dec;
    localparam int N         = 6;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fnd_scan_dec_if #(.NUM_DIGIT(N)) bus_a ();
    fnd_scan_dec_if #(.NUM_DIGIT(N)) bus_b ();

    assign bus_b.i_digits     = bus_a.i_digits;
    assign bus_b.i_dis_mask   = bus_a.i_dis_mask;
    assign bus_b.i_blink_mask = bus_a.i_blink_mask;
    assign bus_b.i_dot        = bus_a.i_dot;
    assign bus_b.i_blink_en   = bus_a.i_blink_en;

    // A: decimal only, segments active-high, commons active-low
    fnd_scan_dec #(.NUM_DIGIT(N), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV),
                   .HEX_EN(1'b0), .SEG_ACT_LOW(1'b0), .COM_ACT_LOW(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    // B: hex, segments active-low, commons active-high
    fnd_scan_dec #(.NUM_DIGIT(N), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV),
                   .HEX_EN(1'b1), .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int         idx;
        logic [7:0] seg_a;
        logic [N-1:0] com_a;
        logic [7:0] seg_b;
        logic [N-1:0] com_b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    bit   done   = 0;

    logic [6:0] seg_tab [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                                   7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    function automatic logic [7:0] raw_seg(input logic [3:0] code, input bit hex,
                                           input bit vis, input bit dp);
        if (!vis) return 8'h00;
        if (code >= 4'd10 && !hex) return {dp, 7'b0000000};
        return {dp, seg_tab[code]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: time since reset decides scan slot and blink phase.
    int               k = 0;
    bit               model_ph = 1'b1;
    logic [4*N-1:0]   s_dig;
    logic [N-1:0]     s_dis, s_blk, s_dot;
    always @(posedge clk) begin
        exp_t e;
        int d;
        logic [3:0] code;
        bit vis;
        logic [7:0] ra, rb;
        if (rst) begin
            k = 0;
            model_ph = 1'b1;
            e.idx = 0; e.seg_a = 8'h00; e.com_a = '1; e.seg_b = 8'hFF; e.com_b = '0;
            q.push_back(e);
        end else begin
            k++;
            model_ph = ((k / BLINK_DIV) % 2) == 0;
            if (k % SCAN_DIV == 0) begin
                d = ((k / SCAN_DIV) - 1) % N;
                if (d == 0) begin
                    s_dig = bus_a.i_digits;   s_dis = bus_a.i_dis_mask;
                    s_blk = bus_a.i_blink_mask; s_dot = bus_a.i_dot;
                end
                code = 4'((s_dig >> (4 * d)) & 'hF);
                vis  = s_dis[d] && !(bus_a.i_blink_en && s_blk[d] && !model_ph);
                ra   = raw_seg(code, 1'b0, vis, s_dot[d]);
                rb   = raw_seg(code, 1'b1, vis, s_dot[d]);
                e.idx = d;
                e.seg_a = ra;  e.com_a = ~(N'(1) << d);
                e.seg_b = ~rb; e.com_b = N'(1) << d;
                q.push_back(e);
            end
        end
    end

    // Monitor: new expectation after each tick/reset, otherwise outputs must hold.
    initial begin
        exp_t cur;
        bit   have = 0;
        while (!done) begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur  = q.pop_front();
                have = 1;
            end
            if (have) begin
                chk("idx_a", 32'(bus_a.o_digit_idx), 32'(cur.idx));
                chk("idx_b", 32'(bus_b.o_digit_idx), 32'(cur.idx));
                chk("seg_a", 32'(bus_a.o_seg), 32'(cur.seg_a));
                chk("seg_b", 32'(bus_b.o_seg), 32'(cur.seg_b));
                chk("com_a", 32'(bus_a.o_com), 32'(cur.com_a));
                chk("com_b", 32'(bus_b.o_com), 32'(cur.com_b));
                chk("blink_ph", 32'(bus_a.o_blink_ph), 32'(model_ph));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idx(input int v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(bus_a.o_digit_idx) == v) return;
        end
        checks++;
        $display("FAIL wait_idx: digit %0d never reached, expected within 200 cycles", v);
    endtask

    initial begin
        bus_a.i_digits     = 24'h123456;
        bus_a.i_dis_mask   = '1;
        bus_a.i_blink_mask = '0;
        bus_a.i_dot        = '0;
        bus_a.i_blink_en   = 1'b0;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(2 * N * SCAN_DIV);

        wait_idx(2);
        bus_a.i_digits = 24'h999999;
        cycles(3 * N * SCAN_DIV);

        bus_a.i_blink_mask = 6'b000011;
        bus_a.i_blink_en   = 1'b1;
        cycles(8 * N * SCAN_DIV);
        bus_a.i_blink_en   = 1'b0;
        cycles(2 * N * SCAN_DIV);

        bus_a.i_digits = 24'h12345E;
        bus_a.i_dot    = 6'b000001;
        cycles(2 * N * SCAN_DIV);
        bus_a.i_dis_mask = 6'b111110;
        cycles(2 * N * SCAN_DIV);
        bus_a.i_digits   = 24'h888888;
        bus_a.i_dis_mask = '1;
        bus_a.i_dot      = '1;
        cycles(2 * N * SCAN_DIV);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 7))
                0: bus_a.i_digits     = 24'($urandom);
                1: bus_a.i_dis_mask   = 6'($urandom);
                2: bus_a.i_blink_mask = 6'($urandom);
                3: bus_a.i_dot        = 6'($urandom);
                4: bus_a.i_blink_en   = 1'($urandom);
                default: ;
            endcase
        end

        wait_idx(4);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(3 * N * SCAN_DIV);

        done = 1;
        cycles(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
